// File: rtl/core_sequencer.sv
// Multi-cycle sequencer for the 9-bit core: owns the PC, paces ROM fetch,
// stalls on data-memory handshakes, resolves branches via the jump LUT, detects HALT.
module core_sequencer #(
  parameter int unsigned PC_W        = 10,
  parameter logic [1:0]  LOAD_OP     = 2'b10,
  parameter logic [1:0]  STORE_OP    = 2'b11,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [8:0]      Instruction,
  input  logic            Branch_flag,
  input  logic [PC_W-1:0] Lut_target,
  input  logic            Mem_ready,
  output logic [PC_W-1:0] PC,
  output logic [5:0]      Lut_index,
  output logic            Commit,
  output logic            Mem_req,
  output logic            Done,
  output logic            Error,
  output logic [31:0]     Cycle_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_EXEC     = 3'd2;
  localparam logic [2:0] S_MEM_WAIT = 3'd3;
  localparam logic [2:0] S_HALT     = 3'd4;

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              is_halt;
  logic              is_mem;
  logic              taken;
  logic              wait_last;
  logic              restart;
  logic              running;

  assign Lut_index = Instruction[5:0];
  assign is_halt   = (Instruction == 9'h07F);
  assign is_mem    = Instruction[8] &&
                     ((Instruction[7:6] == LOAD_OP) || (Instruction[7:6] == STORE_OP));
  // Unconditional branches ignore the flag; conditional ones need it set.
  assign taken     = !Instruction[8] && Instruction[6] && (!Instruction[7] || Branch_flag);
  assign wait_last = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign restart   = ((state == S_IDLE) || (state == S_HALT)) && Start;
  assign running   = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM_WAIT);
  assign Done      = (state == S_HALT);

  always_comb begin
    state_next = state;
    Commit     = 1'b0;
    Mem_req    = 1'b0;
    case (state)
      S_IDLE:  if (Start) state_next = S_FETCH;
      S_FETCH: state_next = S_EXEC;
      S_EXEC: begin
        if (is_halt) begin
          state_next = S_HALT;
        end else if (is_mem) begin
          Mem_req = 1'b1;
          if (Mem_ready) begin
            Commit     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_MEM_WAIT;
          end
        end else begin
          Commit     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEM_WAIT: begin
        Mem_req = 1'b1;
        if (Mem_ready) begin
          Commit     = 1'b1;
          state_next = S_FETCH;
        end else if (wait_last) begin
          state_next = S_HALT;
        end
      end
      S_HALT:  if (Start) state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      PC          <= '0;
      Error       <= 1'b0;
      Cycle_count <= '0;
      wait_cnt    <= '0;
    end else begin
      state <= state_next;
      if (restart) begin
        PC          <= '0;
        Cycle_count <= '0;
        Error       <= 1'b0;
      end else begin
        if (running && (Cycle_count != '1))
          Cycle_count <= Cycle_count + 32'd1;
        if (Commit)
          PC <= taken ? Lut_target : PC + PC_W'(1);
      end
      if (state == S_EXEC)
        wait_cnt <= '0;
      else if (state == S_MEM_WAIT)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if ((state == S_MEM_WAIT) && !Mem_ready && wait_last)
        Error <= 1'b1;
    end
  end

endmodule
